song_reader: RTL and testbench



---
 rtl/music_pkg.sv | 14 +
 rtl/song_reader_if.sv | 14 +
 rtl/song_rom.sv | 16 +
 rtl/song_reader.sv | 57 +++++
 tb/tb_song_reader.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// music_pkg: shared widths, end-of-song markers and reader state encoding
package music_pkg;
   localparam int NOTE_W = 6;
   localparam int DUR_W = 6;
   localparam int IDX_W = 5;
   localparam int SONG_W = 2;
   localparam int ADDR_W = SONG_W + IDX_W;
   localparam int ROM_W = NOTE_W + DUR_W;
   localparam int ROM_DEPTH = 1 << ADDR_W;
   localparam int ROM_BITS = ROM_DEPTH * ROM_W;
   localparam logic [DUR_W-1:0] END_DUR = '0;
   localparam logic [NOTE_W-1:0] REST_NOTE = '0;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, DONE} state_t;
endpackage

// File: rtl/song_reader_if.sv
// song_reader_if: controller/note-player handshake bundle around the song reader
interface song_reader_if;
   import music_pkg::*;
   logic play;
   logic [SONG_W-1:0] song;
   logic reset_play;
   logic note_done;
   logic new_note;
   logic [NOTE_W-1:0] note;
   logic [DUR_W-1:0] duration;
   logic song_done;
   modport master (output play, song, reset_play, note_done, input new_note, note, duration, song_done);
   modport slave (input play, song, reset_play, note_done, output new_note, note, duration, song_done);
endinterface

// File: rtl/song_rom.sv
// song_rom: 128-entry {note, duration} table with a registered, enabled read
module song_rom
   import music_pkg::*;
#(
   parameter logic [ROM_BITS-1:0] INIT = '0
) (
   input logic clk,
   input logic en,
   input logic [ADDR_W-1:0] addr,
   output logic [ROM_W-1:0] data
);
   // read only on fetch so a song change mid-note cannot disturb decoded data
   always_ff @(posedge clk) begin
      if (en) data <= INIT[addr*ROM_W +: ROM_W];
   end
endmodule

// File: rtl/song_reader.sv
// song_reader: walks a song's note table and hands notes to the note player
module song_reader
   import music_pkg::*;
#(
   parameter logic [ROM_BITS-1:0] ROM_INIT = '0
) (
   input logic clk,
   input logic reset,
   song_reader_if.slave bus
);
   state_t state, state_n;
   logic [IDX_W-1:0] index;
   logic [ROM_W-1:0] rom_data;
   logic [NOTE_W-1:0] rom_note;
   logic [DUR_W-1:0] rom_dur;
   logic fire;
   assign rom_note = rom_data[ROM_W-1:DUR_W];
   assign rom_dur = rom_data[DUR_W-1:0];
   assign fire = state == DECODE && bus.play && rom_dur != END_DUR;
   song_rom #(.INIT(ROM_INIT)) u_rom (
      .clk(clk),
      .en(state == FETCH),
      .addr({bus.song, index}),
      .data(rom_data)
   );
   // next state: pause freezes DECODE, the last table slot ends the song
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = bus.play ? FETCH : IDLE;
         FETCH: state_n = DECODE;
         DECODE: state_n = !bus.play ? DECODE : (rom_dur == END_DUR ? DONE : WAIT);
         WAIT: state_n = !bus.note_done ? WAIT : (index == '1 ? DONE : IDLE);
         default: state_n = DONE;
      endcase
   end
   // state, index and output registers; rewind has the same effect as reset
   always_ff @(posedge clk) begin
      if (!reset || bus.reset_play) begin
         state <= IDLE;
         index <= '0;
         bus.new_note <= 1'b0;
         bus.note <= REST_NOTE;
         bus.duration <= '0;
         bus.song_done <= 1'b0;
      end else begin
         state <= state_n;
         bus.new_note <= fire;
         if (fire) begin
            bus.note <= rom_note;
            bus.duration <= rom_dur;
         end
         if (state == WAIT && bus.note_done && index != '1) index <= index + 1'b1;
         bus.song_done <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: randomized note-player timing checked against a table-walk model
module tb_song_reader;
   import music_pkg::*;

   function automatic logic [ROM_W-1:0] entry(input int s, input int i);
      logic [NOTE_W-1:0] n;
      logic [DUR_W-1:0] d;
      n = '0;
      d = '0;
      if (s == 0 && i == 0) begin n = 6'd10; d = 6'd4; end
      if (s == 0 && i == 1) begin n = 6'd12; d = 6'd8; end
      if (s == 1 && i < 7) begin n = 6'((i * 7 + 1) % 64); d = 6'((i * 3) % 5 + 1); end
      if (s == 2 && i < 20) begin n = 6'((i * 11) % 64); d = 6'(i % 4 + 1); end
      if (s == 3) begin n = 6'((i * 5 + 3) % 64); d = 6'(i % 63 + 1); end
      return {n, d};
   endfunction

   function automatic logic [ROM_BITS-1:0] mk_rom();
      logic [ROM_BITS-1:0] r;
      r = '0;
      for (int a = 0; a < ROM_DEPTH; a++) r[a*ROM_W +: ROM_W] = entry(a / 32, a % 32);
      return r;
   endfunction

   localparam logic [ROM_BITS-1:0] ROM = mk_rom();

   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int failures = 0;
   song_reader_if bus();
   song_reader #(.ROM_INIT(ROM)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic rewind(input int s, input string tag);
      bus.song = 2'(s);
      bus.reset_play = 1'b1;
      tick();
      bus.reset_play = 1'b0;
      chk(tag, {bus.new_note, bus.note, bus.duration, bus.song_done}, 0);
   endtask

   // plays song s from its first note; stop_n>0 stops in WAIT after that many notes
   task automatic play_through(input int s, input bit pauses, input int dly, input int stop_n);
      logic [ROM_W-1:0] q[$];
      logic [ROM_W-1:0] e;
      int n, cyc, d, p;
      bit ok;
      for (int i = 0; i < 32; i++) begin
         e = entry(s, i);
         if (e[DUR_W-1:0] == 0) break;
         q.push_back(e);
      end
      bus.play = 1'b1;
      n = 0;
      while (q.size() > 0 && n != stop_n) begin
         cyc = 0;
         do begin
            tick();
            bus.note_done = 1'b0;
            cyc++;
         end while (!bus.new_note && cyc < 60);
         chk("new_note_seen", 32'(bus.new_note), 1);
         if (!bus.new_note) return;
         if (!pauses) chk("latency", cyc, n == 0 ? 3 : 4);
         e = q.pop_front();
         chk("note", 32'(bus.note), 32'(e[ROM_W-1:DUR_W]));
         chk("duration", 32'(bus.duration), 32'(e[DUR_W-1:0]));
         n++;
         ok = 1'b1;
         d = dly > 0 ? dly : int'($urandom_range(1, 5));
         repeat (d) begin
            tick();
            ok &= !bus.new_note;
         end
         if (pauses) begin
            bus.play = 1'b0;
            p = $urandom_range(2, 8);
            repeat (p) begin
               tick();
               ok &= !bus.new_note && bus.note == e[ROM_W-1:DUR_W] && bus.duration == e[DUR_W-1:0];
            end
         end
         chk("hold_between_notes", 32'(ok), 1);
         if (n == stop_n) return;
         bus.note_done = 1'b1;
         bus.play = 1'b1;
      end
      ok = 1'b1;
      cyc = 0;
      do begin
         tick();
         bus.note_done = 1'b0;
         ok &= !bus.new_note;
         cyc++;
      end while (!bus.song_done && cyc < 60);
      chk("no_extra_pulse", 32'(ok), 1);
      chk("song_done_set", 32'(bus.song_done), 1);
      ok = 1'b1;
      repeat (8) begin
         bus.play = 1'($urandom_range(0, 1));
         bus.note_done = 1'($urandom_range(0, 1));
         tick();
         ok &= bus.song_done && !bus.new_note;
      end
      chk("done_hold", 32'(ok), 1);
      bus.play = 1'b1;
      bus.note_done = 1'b0;
   endtask

   initial begin
      bit ok;
      reset = 1'b0;
      bus.play = 1'b1;
      bus.song = '0;
      bus.reset_play = 1'b0;
      bus.note_done = 1'b0;
      ok = 1'b1;
      repeat (5) begin
         tick();
         ok &= {bus.new_note, bus.note, bus.duration, bus.song_done} == 0;
      end
      chk("reset_outputs", 32'(ok), 1);
      reset = 1'b1;
      play_through(0, 1'b0, 5, -1);
      rewind(0, "rewind_clear");
      play_through(0, 1'b1, 0, -1);
      rewind(3, "rewind_clear");
      play_through(3, 1'b0, 0, -1);
      rewind(3, "rewind_clear");
      play_through(3, 1'b0, 0, 6);
      bus.song = 2'd1;
      bus.reset_play = 1'b1;
      bus.note_done = 1'b1;
      tick();
      bus.reset_play = 1'b0;
      bus.note_done = 1'b0;
      chk("collision_clear", {bus.new_note, bus.note, bus.duration, bus.song_done}, 0);
      play_through(1, 1'b0, 0, -1);
      rewind(2, "rewind_clear");
      play_through(2, 1'b1, 0, -1);
      rewind(2, "final_rewind");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
